// File: rtl/mem_pkg.sv
// Shared parameters and types for the burst memory master.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

  localparam int DATA_SIZE  = 8;   // bits per memory word
  localparam int ADDR_WIDTH = 12;  // 4096 locations
  localparam int LEN_WIDTH  = 8;   // burst length field, beats = len + 1

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } mem_burst_state_t;

  // Occupancy of the 2-entry read FIFO rebuilt from its full/empty flags.
  function automatic logic [1:0] fifo_occupancy(input logic full, input logic empty);
    if (full) begin
      return 2'd2;
    end else if (empty) begin
      return 2'd0;
    end
    return 2'd1;
  endfunction

endpackage

// File: rtl/mem_rd_fifo.sv
// Two-entry read-data buffer between memory read port and rdValid/rdReady stream.
// Latency: a push is visible at headData the cycle after it is written.
// Backpressure: push while full (without a pop) is dropped; pop while empty is ignored.
//
// Ports: clock, reset (sync, active-high); push/pushData write side;
//        pop read side; full/empty flags; headData = oldest entry.
module mem_rd_fifo
  import mem_pkg::*;
#(
  parameter int WIDTH = DATA_SIZE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] headData
);

  logic [WIDTH-1:0] slot_q [2];
  logic [WIDTH-1:0] slot_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    // When full, a same-cycle pop frees the slot the push lands in.
    do_push  = push && ((count_q != 2'd2) || do_pop);
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      slot_d[wr_ptr_q] = pushData;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);
  assign headData = slot_q[rd_ptr_q];

endmodule

// File: rtl/mem_burst_master.sv
// Burst command front-end driving a single-port synchronous memory.
// Latency: write beats hit memory combinationally; first read beat appears 2 edges after accept.
// Backpressure: wrReady only in WRITE; reads throttle so buffered + in-flight never exceeds 2.
//
// Ports: clock/reset; cmdValid/cmdReady/cmdWrite/cmdAddr/cmdLen command;
//        wrValid/wrReady/wrData write stream; rdValid/rdReady/rdData read stream;
//        busy; memAddr/memWriteData/memReadEnable/memWriteEnable/memReadData memory side.
module mem_burst_master #(
  parameter int DATA_SIZE  = mem_pkg::DATA_SIZE,
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int LEN_WIDTH  = mem_pkg::LEN_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic                  cmdWrite,
  input  logic [ADDR_WIDTH-1:0] cmdAddr,
  input  logic [LEN_WIDTH-1:0]  cmdLen,
  input  logic                  wrValid,
  output logic                  wrReady,
  input  logic [DATA_SIZE-1:0]  wrData,
  output logic                  rdValid,
  input  logic                  rdReady,
  output logic [DATA_SIZE-1:0]  rdData,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_SIZE-1:0]  memWriteData,
  output logic                  memReadEnable,
  output logic                  memWriteEnable,
  input  logic [DATA_SIZE-1:0]  memReadData
);
  import mem_pkg::*;

  mem_burst_state_t      state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic [DATA_SIZE-1:0]  wdata_hold_q, wdata_hold_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  inflight_q, inflight_d;

  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [DATA_SIZE-1:0]  fifo_head;
  logic [1:0]            occupancy, pending;
  logic                  wr_fire, rd_issue;

  mem_rd_fifo #(
    .WIDTH(DATA_SIZE)
  ) u_rd_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (inflight_q),   // memory data is valid exactly one cycle after the strobe
    .pushData (memReadData),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .headData (fifo_head)
  );

  always_comb begin
    occupancy = fifo_occupancy(fifo_full, fifo_empty);
    fifo_pop  = !reset && !fifo_empty && rdReady;
    // Counting this cycle's pop lets a full-rate stream keep issuing one read per cycle.
    pending   = occupancy + {1'b0, inflight_q} - {1'b0, fifo_pop};

    state_d      = state_q;
    addr_d       = addr_q;
    beat_cnt_d   = beat_cnt_q;
    addr_hold_d  = addr_hold_q;
    wdata_hold_d = wdata_hold_q;
    wr_fire      = 1'b0;
    rd_issue     = 1'b0;
    cmdReady     = 1'b0;
    wrReady      = 1'b0;

    case (state_q)
      IDLE: begin
        cmdReady = 1'b1;
        if (cmdValid) begin
          addr_d     = cmdAddr;
          beat_cnt_d = cmdLen;
          state_d    = cmdWrite ? WRITE : READ;
        end
      end
      WRITE: begin
        wrReady = 1'b1;
        if (wrValid) begin
          wr_fire = 1'b1;
          addr_d  = addr_q + 1'b1;
          if (beat_cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - 1'b1;
          end
        end
      end
      READ: begin
        if (pending < 2'd2) begin
          rd_issue = 1'b1;
          addr_d   = addr_q + 1'b1;
          if (beat_cnt_q == '0) begin
            state_d = DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q - 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && (fifo_empty || (occupancy == 2'd1 && fifo_pop))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset wins over any handshake in flight this cycle.
    if (reset) begin
      cmdReady = 1'b0;
      wrReady  = 1'b0;
      wr_fire  = 1'b0;
      rd_issue = 1'b0;
    end

    inflight_d = rd_issue;
    if (wr_fire || rd_issue) begin
      addr_hold_d = addr_q;
    end
    if (wr_fire) begin
      wdata_hold_d = wrData;
    end

    busy           = !reset && (state_q != IDLE);
    memWriteEnable = wr_fire;
    memReadEnable  = rd_issue;
    // Address/data show the live beat when strobing, otherwise the last value driven.
    memAddr        = reset ? '0 : ((wr_fire || rd_issue) ? addr_q : addr_hold_q);
    memWriteData   = reset ? '0 : (wr_fire ? wrData : wdata_hold_q);
    rdValid        = !reset && !fifo_empty;
    rdData         = reset ? '0 : fifo_head;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beat_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_cnt_q   <= beat_cnt_d;
      inflight_q   <= inflight_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench for mem_burst_master with a behavioural 4096x8 memory.
// Latency: n/a.
// Backpressure: rdReady driven constant, toggling 1,0,0,1, or random.
module tb_mem_burst_master;

  logic        clock;
  logic        reset;
  logic        cmdValid, cmdReady, cmdWrite;
  logic [11:0] cmdAddr;
  logic [7:0]  cmdLen;
  logic        wrValid, wrReady;
  logic [7:0]  wrData;
  logic        rdValid, rdReady;
  logic [7:0]  rdData;
  logic        busy;
  logic [11:0] memAddr;
  logic [7:0]  memWriteData;
  logic        memReadEnable, memWriteEnable;
  logic [7:0]  memReadData;

  mem_burst_master dut (
    .clock          (clock),
    .reset          (reset),
    .cmdValid       (cmdValid),
    .cmdReady       (cmdReady),
    .cmdWrite       (cmdWrite),
    .cmdAddr        (cmdAddr),
    .cmdLen         (cmdLen),
    .wrValid        (wrValid),
    .wrReady        (wrReady),
    .wrData         (wrData),
    .rdValid        (rdValid),
    .rdReady        (rdReady),
    .rdData         (rdData),
    .busy           (busy),
    .memAddr        (memAddr),
    .memWriteData   (memWriteData),
    .memReadEnable  (memReadEnable),
    .memWriteEnable (memWriteEnable),
    .memReadData    (memReadData)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int both_cnt = 0;
  int issued = 0;
  int popped = 0;
  int max_out = 0;
  int mon_out;
  int accept_cyc = 0;
  int rd_mode = 0;
  int tog_idx = 0;
  logic [3:0]  tog_pat;
  logic        wr_gaps;
  logic [19:0] mon_e;
  logic [7:0]  mon_d;

  logic [19:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  int          wr_cyc_q [$];
  int          rd_cyc_q [$];

  logic [7:0] mem_model [0:4095];
  logic [7:0] ref_mem   [0:4095];
  logic [7:0] wbuf      [0:255];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory the DUT talks to: read data one cycle after the read strobe.
  always @(posedge clock) begin
    if (memReadEnable) memReadData <= mem_model[memAddr];
    if (memWriteEnable) mem_model[memAddr] <= memWriteData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every memory write and every read-stream pop against the queues.
  initial forever begin
    @(negedge clock);
    #1;
    if (reset) begin
      issued = 0;
      popped = 0;
    end
    if (memReadEnable && memWriteEnable) both_cnt++;
    if (memWriteEnable) begin
      if (exp_wr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected", memAddr, memWriteData);
      end else begin
        mon_e = exp_wr_q.pop_front();
        check("wr_addr", 32'(memAddr), 32'(mon_e[19:8]));
        check("wr_data", 32'(memWriteData), 32'(mon_e[7:0]));
      end
      wr_cyc_q.push_back(cyc);
    end
    mon_out = issued - popped;
    if (mon_out > max_out) max_out = mon_out;
    if (memReadEnable) issued++;
    if (rdValid && rdReady) begin
      if (exp_rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read_beat: data %0h, no beat expected", rdData);
      end else begin
        mon_d = exp_rd_q.pop_front();
        check("rd_data", 32'(rdData), 32'(mon_d));
      end
      popped++;
      rd_cyc_q.push_back(cyc);
    end
  end

  // Read-side consumer.
  initial forever begin
    @(negedge clock);
    case (rd_mode)
      0: rdReady = 1'b1;
      1: begin
        rdReady = tog_pat[tog_idx % 4];
        tog_idx++;
      end
      default: rdReady = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [7:0] l);
    int t = 0;
    @(negedge clock);
    cmdValid = 1'b1;
    cmdWrite = w;
    cmdAddr  = a;
    cmdLen   = l;
    while (!cmdReady && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!cmdReady) begin
      tests++;
      fails++;
      $display("FAIL cmd_accept_timeout: cmdReady %0b, expected 1", cmdReady);
    end
    @(posedge clock);
    @(negedge clock);
    cmdValid   = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic do_write(input logic [11:0] a, input int len);
    int i = 0;
    int t = 0;
    logic acc;
    for (int k = 0; k <= len; k++) begin
      exp_wr_q.push_back({a + 12'(k), wbuf[k]});
      ref_mem[a + 12'(k)] = wbuf[k];
    end
    send_cmd(1'b1, a, 8'(len));
    while (i <= len && t < 2000) begin
      wrValid = wr_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wrData  = wbuf[i];
      acc     = wrValid && wrReady;
      @(posedge clock);
      if (acc) i++;
      t++;
      @(negedge clock);
    end
    wrValid = 1'b0;
    if (i <= len) begin
      tests++;
      fails++;
      $display("FAIL write_timeout: %0d beats accepted, expected %0d", i, len + 1);
    end
  endtask

  task automatic do_read(input logic [11:0] a, input int len);
    int t = 0;
    for (int k = 0; k <= len; k++) exp_rd_q.push_back(ref_mem[a + 12'(k)]);
    send_cmd(1'b0, a, 8'(len));
    while ((busy || exp_rd_q.size() != 0) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 3000) begin
      tests++;
      fails++;
      $display("FAIL read_timeout: %0d beats outstanding, expected 0", exp_rd_q.size());
    end
  endtask

  initial begin
    logic [11:0] ra;
    int          rl;
    for (int k = 0; k < 4096; k++) begin
      mem_model[k] = 8'h00;
      ref_mem[k]   = 8'h00;
    end
    reset    = 1'b1;
    cmdValid = 1'b0;
    cmdWrite = 1'b0;
    cmdAddr  = '0;
    cmdLen   = '0;
    wrValid  = 1'b0;
    wrData   = '0;
    tog_pat  = 4'b1001;  // rdReady sequence 1,0,0,1
    wr_gaps  = 1'b0;
    rd_mode  = 0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 0);
    check("rst_wrReady", 32'(wrReady), 0);
    check("rst_rdValid", 32'(rdValid), 0);
    check("rst_strobes", 32'({memReadEnable, memWriteEnable}), 0);
    check("rst_memAddr", 32'(memAddr), 0);
    check("rst_memWriteData", 32'(memWriteData), 0);
    check("rst_rdData", 32'(rdData), 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_cmdReady", 32'(cmdReady), 1);
    check("post_rst_busy", 32'(busy), 0);

    // Write burst 0x010 len 3, A0..A3, wrValid held
    for (int k = 0; k < 4; k++) wbuf[k] = 8'hA0 + 8'(k);
    wr_cyc_q.delete();
    do_write(12'h010, 3);
    check("wr4_count", 32'(wr_cyc_q.size()), 4);
    for (int k = 0; k < wr_cyc_q.size(); k++) check("wr4_cycle", 32'(wr_cyc_q[k]), 32'(accept_cyc + k));
    check("wr4_idle_after", 32'(busy), 0);
    check("wr4_cmdReady_after", 32'(cmdReady), 1);

    // Read burst 0x010 len 3 at full rate
    rd_cyc_q.delete();
    do_read(12'h010, 3);
    check("rd4_count", 32'(rd_cyc_q.size()), 4);
    for (int k = 0; k < rd_cyc_q.size(); k++) check("rd4_cycle", 32'(rd_cyc_q[k]), 32'(accept_cyc + 2 + k));

    // len 7 read with rdReady 1,0,0,1
    for (int k = 0; k < 8; k++) wbuf[k] = 8'h30 + 8'(k);
    do_write(12'h020, 7);
    rd_mode = 1;
    tog_idx = 0;
    max_out = 0;
    rd_cyc_q.delete();
    do_read(12'h020, 7);
    rd_mode = 0;
    check("rd8_toggle_count", 32'(rd_cyc_q.size()), 8);
    check("rd8_max_buffered", 32'(max_out), 2);

    // Address wrap
    for (int k = 0; k < 4; k++) wbuf[k] = 8'hC0 + 8'(k);
    do_write(12'hFFE, 3);
    do_read(12'hFFE, 3);

    // Single-beat burst
    wbuf[0] = 8'h5A;
    wr_cyc_q.delete();
    do_write(12'h3FF, 0);
    check("wr1_count", 32'(wr_cyc_q.size()), 1);
    do_read(12'h3FF, 0);

    // Reset on the 3rd beat of a len 7 write
    for (int k = 0; k < 8; k++) wbuf[k] = 8'h70 + 8'(k);
    for (int k = 0; k < 2; k++) begin
      exp_wr_q.push_back({12'h100 + 12'(k), wbuf[k]});
      ref_mem[12'h100 + 12'(k)] = wbuf[k];
    end
    send_cmd(1'b1, 12'h100, 8'd7);
    for (int b = 0; b < 3; b++) begin
      wrValid = 1'b1;
      wrData  = wbuf[b];
      if (b == 2) reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
    end
    check("midrst_busy", 32'(busy), 0);
    check("midrst_wrReady", 32'(wrReady), 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_cmdReady_after", 32'(cmdReady), 1);
    check("midrst_busy_after", 32'(busy), 0);
    check("midrst_wrReady_after", 32'(wrReady), 0);
    check("midrst_memAddr_after", 32'(memAddr), 0);
    check("midrst_memWriteData_after", 32'(memWriteData), 0);
    repeat (3) @(negedge clock);  // wrValid still high in IDLE
    wrValid = 1'b0;
    check("midrst_no_extra_writes", 32'(exp_wr_q.size()), 0);
    do_read(12'h100, 1);

    // Mixed bursts with gaps and random consumer
    wr_gaps = 1'b1;
    rd_mode = 2;
    for (int n = 0; n < 12; n++) begin
      ra = 12'($urandom_range(0, 4095));
      rl = $urandom_range(0, 15);
      for (int k = 0; k <= rl; k++) wbuf[k] = 8'($urandom_range(0, 255));
      do_write(ra, rl);
      do_read(ra + 12'($urandom_range(0, 3)), rl);
    end

    // 256-beat bursts across the top of the address space
    wr_gaps = 1'b0;
    rd_mode = 0;
    for (int k = 0; k < 256; k++) wbuf[k] = 8'($urandom_range(0, 255));
    wr_cyc_q.delete();
    do_write(12'hF80, 255);
    check("wr256_count", 32'(wr_cyc_q.size()), 256);
    rd_cyc_q.delete();
    do_read(12'hF80, 255);
    check("rd256_count", 32'(rd_cyc_q.size()), 256);

    repeat (3) @(negedge clock);
    check("exp_wr_drained", 32'(exp_wr_q.size()), 0);
    check("exp_rd_drained", 32'(exp_rd_q.size()), 0);
    check("both_strobes_cycles", 32'(both_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
